mseq_frame_ctrl: RTL and testbench

Frame controller that sequences an M-sequence (maximal-length LFSR) bit source into framed test data for the convolutional encoder. On each start it optionally reseeds the generator, emits frame_len payload bits over a valid/ready stream, then appends TAIL zero bits to flush the encoder. It contains its own handshake-gated LFSR, so the sequence advances only on accepted payload bits.

---
 rtl/mseq_frame_ctrl.sv | 149 ++++++++++++++
 tb/tb_mseq_frame_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mseq_frame_ctrl.sv
// Frame controller: wraps a handshake-gated x^15+x^14+1 M-sequence source into
// frames of frame_len payload bits followed by TAIL zero flush bits.
module mseq_frame_ctrl #(
  parameter int unsigned LEN     = 15,
  parameter int unsigned FRAME_W = 16,
  parameter int unsigned TAIL    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               reseed,
  input  logic [LEN-1:0]     seed,
  input  logic [FRAME_W-1:0] frame_len,
  input  logic               abort,
  output logic               out_bit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sof,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam int unsigned TCW       = (TAIL > 1) ? $clog2(TAIL) : 1;
  localparam int unsigned TAIL_LAST = (TAIL > 0) ? TAIL - 1 : 0;
  localparam logic [LEN-1:0] ONES   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAYLOAD,
    S_TAIL,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [LEN-1:0]     lfsr_q, lfsr_d;
  logic [LEN-1:0]     seed_q, seed_d;
  logic [FRAME_W-1:0] len_q, len_d;
  logic [FRAME_W-1:0] cnt_q, cnt_d;
  logic [TCW-1:0]     tcnt_q, tcnt_d;
  logic               reseed_q, reseed_d;
  logic               out_bit_q, out_bit_d;
  logic               out_valid_q, out_valid_d;
  logic               out_sof_q, out_sof_d;
  logic               out_last_q, out_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // State register and all datapath/output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= ONES;
      seed_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      reseed_q    <= 1'b0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      seed_q      <= seed_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      reseed_q    <= reseed_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state, LFSR/counter update, and registered output precompute
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    seed_d   = seed_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    reseed_d = reseed_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          len_d    = frame_len;
          reseed_d = reseed;
          seed_d   = seed;
          cnt_d    = '0;
          tcnt_d   = '0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (reseed_q) lfsr_d = (seed_q == '0) ? ONES : seed_q;
        if (len_q != '0)   state_d = S_PAYLOAD;
        else if (TAIL > 0) state_d = S_TAIL;
        else               state_d = S_DONE;
      end
      S_PAYLOAD: begin
        if (out_ready) begin
          lfsr_d = {lfsr_q[LEN-2:0], lfsr_q[LEN-1] ^ lfsr_q[LEN-2]};
          if (cnt_q == len_q - FRAME_W'(1)) state_d = (TAIL > 0) ? S_TAIL : S_DONE;
          else                              cnt_d   = cnt_q + FRAME_W'(1);
        end
      end
      S_TAIL: begin
        if (out_ready) begin
          if (tcnt_q == TCW'(TAIL_LAST)) state_d = S_DONE;
          else                           tcnt_d  = tcnt_q + TCW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort discards any coincident transfer: the LFSR keeps the unsent bit
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      lfsr_d  = lfsr_q;
    end

    out_valid_d = (state_d == S_PAYLOAD) || (state_d == S_TAIL);
    out_bit_d   = (state_d == S_PAYLOAD) && lfsr_d[LEN-1];
    out_sof_d   = (state_d == S_PAYLOAD) && (cnt_d == '0);
    out_last_d  = ((state_d == S_TAIL) && (tcnt_d == TCW'(TAIL_LAST))) ||
                  ((TAIL == 0) && (state_d == S_PAYLOAD) && (cnt_d == len_d - FRAME_W'(1)));
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mseq_frame_ctrl.sv
// Scoreboard bench for mseq_frame_ctrl: stimulus pushes expected beats, a
// negedge monitor pops and compares every presented beat.
module tb_mseq_frame_ctrl;

  localparam int unsigned LEN     = 15;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned TAIL    = 6;
  localparam logic [LEN-1:0] ONES = '1;

  typedef struct packed {
    logic b;
    logic sof;
    logic last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic reseed = 1'b0;
  logic [LEN-1:0] seed = '0;
  logic [FRAME_W-1:0] frame_len = '0;
  logic abort = 1'b0;
  logic out_ready = 1'b1;
  logic out_bit, out_valid, out_sof, out_last, busy, done;

  logic start0 = 1'b0;
  logic reseed0 = 1'b0;
  logic [FRAME_W-1:0] len0 = '0;
  logic abort0 = 1'b0;
  logic ready0 = 1'b1;
  logic bit0, v0, sof0, last0, busy0, done0;

  int n_checks = 0;
  int n_fail   = 0;
  beat_t sb[$];
  logic  rx[$];
  logic [LEN-1:0] ref_r = ONES;
  int done_cnt = 0, busy_cnt = 0;
  int n0 = 0, last_at0 = 0, sof_at0 = 0, dd0 = 0, bitsum0 = 0;

  always #5 clk = ~clk;

  mseq_frame_ctrl #(.LEN(LEN), .FRAME_W(FRAME_W), .TAIL(TAIL)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reseed(reseed), .seed(seed),
    .frame_len(frame_len), .abort(abort), .out_bit(out_bit), .out_valid(out_valid),
    .out_ready(out_ready), .out_sof(out_sof), .out_last(out_last), .busy(busy), .done(done)
  );

  mseq_frame_ctrl #(.LEN(LEN), .FRAME_W(FRAME_W), .TAIL(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .reseed(reseed0), .seed(seed),
    .frame_len(len0), .abort(abort0), .out_bit(bit0), .out_valid(v0),
    .out_ready(ready0), .out_sof(sof0), .out_last(last0), .busy(busy0), .done(done0)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [LEN-1:0] lfsr_step(input logic [LEN-1:0] r);
    return {r[LEN-2:0], r[LEN-1] ^ r[LEN-2]};
  endfunction

  // Expected frame: optional reseed, len payload bits, then TAIL zeros
  task automatic push_frame(input bit rs, input logic [LEN-1:0] sd, input int len);
    beat_t e;
    if (rs) ref_r = (sd == '0) ? ONES : sd;
    for (int i = 0; i < len; i++) begin
      e = '{b: ref_r[LEN-1], sof: (i == 0), last: 1'b0};
      sb.push_back(e);
      ref_r = lfsr_step(ref_r);
    end
    for (int i = 0; i < int'(TAIL); i++) begin
      e = '{b: 1'b0, sof: 1'b0, last: (i == int'(TAIL) - 1)};
      sb.push_back(e);
    end
  endtask

  task automatic start_frame(input bit rs, input logic [LEN-1:0] sd, input logic [FRAME_W-1:0] len);
    @(posedge clk); #1;
    start = 1'b1; reseed = rs; seed = sd; frame_len = len;
    @(posedge clk); #1;
    start = 1'b0; reseed = 1'b0;
  endtask

  task automatic wait_done(input bit toggle, input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        if (toggle) out_ready = ~out_ready;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    out_ready = 1'b1;
  endtask

  function automatic logic [31:0] rx_word(input int base, input int n);
    logic [31:0] w = '0;
    for (int i = 0; i < n; i++) w = {w[30:0], rx[base + i]};
    return w;
  endfunction

  // Scoreboard monitor: compare every presented beat, pop on handshake
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'(out_valid), 32'd0);
        end else begin
          e = sb[0];
          check("out_bit", 32'(out_bit), 32'(e.b));
          check("out_sof", 32'(out_sof), 32'(e.sof));
          check("out_last", 32'(out_last), 32'(e.last));
          if (out_ready) begin
            void'(sb.pop_front());
            if (!abort) rx.push_back(out_bit);
          end
        end
      end
    end
  end

  // Monitor for the TAIL=0 instance
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (v0 && ready0) begin
        n0++;
        bitsum0 += int'(bit0);
        if (last0) last_at0 = n0;
        if (sof0) sof_at0 = n0;
      end
      if (done0) dd0++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, b0, base, base2;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_bit",   32'(out_bit),   32'd0);
    check("rst_sof",   32'(out_sof),   32'd0);
    check("rst_last",  32'(out_last),  32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);

    // Basic frame, ready always high
    base = rx.size(); d0 = done_cnt; b0 = busy_cnt;
    push_frame(1'b1, 15'h7FFF, 20);
    start_frame(1'b1, 15'h7FFF, 16'd20);
    wait_done(1'b0, 100);
    @(negedge clk);
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t1_busy_cycles", 32'(busy_cnt - b0), 32'd28);
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);
    check("t1_first16", rx_word(base, 16), 32'h0000_FFFE);

    // Same frame with ready toggling: stalls must hold outputs and LFSR
    d0 = done_cnt;
    push_frame(1'b1, 15'h7FFF, 20);
    start_frame(1'b1, 15'h7FFF, 16'd20);
    wait_done(1'b1, 200);
    @(negedge clk);
    check("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Back-to-back frames; second continues sequence, start while busy ignored
    d0 = done_cnt;
    push_frame(1'b1, 15'h7FFF, 10);
    start_frame(1'b1, 15'h7FFF, 16'd10);
    wait_done(1'b0, 100);
    push_frame(1'b0, 15'h0, 10);
    base2 = rx.size();
    start_frame(1'b0, 15'h0, 16'd10);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; reseed = 1'b1; seed = 15'h1234; frame_len = 16'd3;
    @(posedge clk); #1 start = 1'b0; reseed = 1'b0;
    wait_done(1'b0, 100);
    @(negedge clk);
    check("t3_done_cnt", 32'(done_cnt - d0), 32'd2);
    check("t3_frame2_bits", rx_word(base2, 10), 32'b11_1110_0000);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // All-zero seed behaves as all-ones
    base = rx.size();
    push_frame(1'b1, 15'h0, 20);
    start_frame(1'b1, 15'h0, 16'd20);
    wait_done(1'b0, 100);
    check("t4_first16", rx_word(base, 16), 32'h0000_FFFE);

    // frame_len=0: tail only, no sof
    base = rx.size();
    push_frame(1'b0, 15'h0, 0);
    start_frame(1'b0, 15'h0, 16'd0);
    wait_done(1'b0, 50);
    @(negedge clk);
    check("t5_tail_count", 32'(rx.size() - base), 32'd6);
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    // Abort on the 5th payload transfer
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{b: ref_r[LEN-1], sof: (i == 0), last: 1'b0});
      if (i < 4) ref_r = lfsr_step(ref_r);
    end
    start_frame(1'b0, 15'h0, 16'd10);
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("t6_valid_after_abort", 32'(out_valid), 32'd0);
    check("t6_busy_after_abort", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);
    push_frame(1'b0, 15'h0, 8);
    start_frame(1'b0, 15'h0, 16'd8);
    wait_done(1'b0, 100);
    @(negedge clk);
    check("t6_resume_sb_empty", 32'(sb.size()), 32'd0);

    // start together with abort in IDLE is dropped
    @(posedge clk); #1 start = 1'b1; abort = 1'b1; frame_len = 16'd5;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of payload
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{b: ref_r[LEN-1], sof: (i == 0), last: 1'b0});
      ref_r = lfsr_step(ref_r);
    end
    start_frame(1'b0, 15'h0, 16'd10);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t8_valid", 32'(out_valid), 32'd0);
    check("t8_bit", 32'(out_bit), 32'd0);
    check("t8_sof", 32'(out_sof), 32'd0);
    check("t8_last", 32'(out_last), 32'd0);
    check("t8_busy", 32'(busy), 32'd0);
    check("t8_done", 32'(done), 32'd0);
    check("t8_lfsr", 32'(u_dut.lfsr_q), 32'h7FFF);
    check("t8_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    ref_r = ONES;
    base = rx.size();
    push_frame(1'b0, 15'h0, 16);
    start_frame(1'b0, 15'h0, 16'd16);
    wait_done(1'b0, 100);
    check("t8_post_reset16", rx_word(base, 16), 32'h0000_FFFE);

    // TAIL=0 build: frame_len=0 pulses done with no valid
    d0 = dd0; b0 = n0;
    @(posedge clk); #1 start0 = 1'b1; reseed0 = 1'b1; len0 = 16'd0;
    @(posedge clk); #1 start0 = 1'b0; reseed0 = 1'b0;
    repeat (5) @(negedge clk);
    check("t9_done0", 32'(dd0 - d0), 32'd1);
    check("t9_no_valid0", 32'(n0 - b0), 32'd0);
    check("t9_busy0", 32'(busy0), 32'd0);
    // TAIL=0 build: last on final payload bit
    d0 = dd0; b0 = n0;
    @(posedge clk); #1 start0 = 1'b1; reseed0 = 1'b1; len0 = 16'd3;
    @(posedge clk); #1 start0 = 1'b0; reseed0 = 1'b0;
    repeat (8) @(negedge clk);
    check("t9_xfers0", 32'(n0 - b0), 32'd3);
    check("t9_last_at0", 32'(last_at0 - b0), 32'd3);
    check("t9_sof_at0", 32'(sof_at0 - b0), 32'd1);
    check("t9_bits0", 32'(bitsum0), 32'd3);
    check("t9_done0b", 32'(dd0 - d0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
